fmul_arbiter: RTL and testbench

FMUL_ARBITER -- requirements
Module: fmul_arbiter

---
 rtl/fmul_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fmul_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Two-requester round-robin front end for one shared pipelined multiplier, with a credit-guarded result FIFO per requester.
// Issue one edge after acceptance, result visible MUL_LATENCY+2 edges after; a requester out of credit is held off without stalling the other.
module fmul_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Credits upstream make a write into a full FIFO impossible.
    overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

module fmul_arbiter #(
    parameter int MUL_LATENCY  = 3,
    parameter int RESULT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        res0_valid,
    output logic [31:0] res0_data,
    output logic        res0_exception,
    input  logic        res0_ready,
    output logic        res1_valid,
    output logic [31:0] res1_data,
    output logic        res1_exception,
    input  logic        res1_ready,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_exception,
    output logic        busy
);
    localparam int CW = $clog2(RESULT_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CREDIT = CW'(RESULT_DEPTH);

    logic [CW-1:0]          credit0;
    logic [CW-1:0]          credit1;
    logic                   rr_ptr;
    logic                   elig0, elig1;
    logic                   grant0, grant1;
    logic                   pop0, pop1;
    logic                   mul_id;
    logic [MUL_LATENCY-1:0] tag_vld;
    logic [MUL_LATENCY-1:0] tag_id;
    logic                   wb_vld;
    logic                   wb_id;
    logic [32:0]            wb_dat;
    logic [32:0]            head0, head1;
    logic                   empty0, empty1;

    assign elig0  = !reset && req0_valid && (credit0 != '0);
    assign elig1  = !reset && req1_valid && (credit1 != '0);
    assign grant0 = elig0 && (!elig1 || !rr_ptr);
    assign grant1 = elig1 && (!elig0 || rr_ptr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign pop0       = !empty0 && res0_ready;
    assign pop1       = !empty1 && res1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= 1'b0;
            credit0   <= FULL_CREDIT;
            credit1   <= FULL_CREDIT;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_id    <= 1'b0;
        end else begin
            mul_valid <= grant0 | grant1;
            if (grant0 | grant1) begin
                mul_a  <= grant0 ? req0_a : req1_a;
                mul_b  <= grant0 ? req0_b : req1_b;
                mul_id <= grant1;
                // Next priority goes to whoever was not just served.
                rr_ptr <= grant0;
            end
            if (grant0 && !pop0)      credit0 <= credit0 - CW'(1);
            else if (pop0 && !grant0) credit0 <= credit0 + CW'(1);
            if (grant1 && !pop1)      credit1 <= credit1 - CW'(1);
            else if (pop1 && !grant1) credit1 <= credit1 + CW'(1);
        end
    end

    // Tag follows the operation through the multiplier; the extra wb stage registers the product before the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            tag_id  <= '0;
            wb_vld  <= 1'b0;
            wb_id   <= 1'b0;
            wb_dat  <= '0;
        end else begin
            tag_vld[0] <= mul_valid;
            tag_id[0]  <= mul_id;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            wb_vld <= tag_vld[MUL_LATENCY-1];
            wb_id  <= tag_id[MUL_LATENCY-1];
            wb_dat <= {mul_exception, mul_result};
        end
    end

    fmul_fifo #(.WIDTH(33), .DEPTH(RESULT_DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (wb_vld && !wb_id),
        .push_data (wb_dat),
        .pop       (pop0),
        .head      (head0),
        .empty     (empty0)
    );

    fmul_fifo #(.WIDTH(33), .DEPTH(RESULT_DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (wb_vld && wb_id),
        .push_data (wb_dat),
        .pop       (pop1),
        .head      (head1),
        .empty     (empty1)
    );

    assign res0_valid     = !empty0;
    assign res0_data      = head0[31:0];
    assign res0_exception = head0[32];
    assign res1_valid     = !empty1;
    assign res1_data      = head1[31:0];
    assign res1_exception = head1[32];

    assign busy = mul_valid | (|tag_vld) | wb_vld | !empty0 | !empty1;
endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_fmul_arbiter;
    localparam int L = 3;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        res0_valid, res1_valid;
    logic [31:0] res0_data, res1_data;
    logic        res0_exception, res1_exception;
    logic        res0_ready, res1_ready;
    logic        mul_valid;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        mul_exception;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fmul_arbiter #(.MUL_LATENCY(L), .RESULT_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res0_valid(res0_valid), .res0_data(res0_data), .res0_exception(res0_exception), .res0_ready(res0_ready),
        .res1_valid(res1_valid), .res1_data(res1_data), .res1_exception(res1_exception), .res1_ready(res1_ready),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_exception(mul_exception),
        .busy(busy)
    );

    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    // {exception, product}; Inf/NaN operands raise the exception flag.
    function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [31:0] r;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
        d = $realtobits(sp2r(a) * sp2r(b));
        if (d[62:0] == 63'd0) r = {d[63], 31'd0};
        else r = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
        return {1'b0, r};
    endfunction

    // External multiplier: product valid L cycles after mul_valid, garbage otherwise.
    logic        mv_pipe [1:L];
    logic [31:0] ma_pipe [1:L];
    logic [31:0] mb_pipe [1:L];
    always @(posedge clk) begin
        mv_pipe[1] <= mul_valid;
        ma_pipe[1] <= mul_a;
        mb_pipe[1] <= mul_b;
        for (int i = 2; i <= L; i++) begin
            mv_pipe[i] <= mv_pipe[i-1];
            ma_pipe[i] <= ma_pipe[i-1];
            mb_pipe[i] <= mb_pipe[i-1];
        end
    end
    assign {mul_exception, mul_result} = mv_pipe[L] ? fmul_ref(ma_pipe[L], mb_pipe[L]) : {1'b1, 32'hDEADBEEF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding operations per requester, each with the edge count at which its result shows.
    typedef struct {
        logic [32:0] dat;
        int          vis;
    } ent_t;
    ent_t        q0[$];
    ent_t        q1[$];
    int          ne = 0;
    bit          started = 0;
    bit          m_ptr = 0;
    bit          m_mv = 0;
    logic [31:0] m_ma = '0;
    logic [31:0] m_mb = '0;

    always @(negedge clk) begin : cmp
        bit el0, el1, g0, g1, rv0, rv1;
        #3;
        rv0 = (q0.size() > 0) && (q0[0].vis <= ne);
        rv1 = (q1.size() > 0) && (q1[0].vis <= ne);
        el0 = !reset && req0_valid && (q0.size() < D);
        el1 = !reset && req1_valid && (q1.size() < D);
        g0  = el0 && (!el1 || !m_ptr);
        g1  = el1 && (!el0 || m_ptr);
        if (started) begin
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
            check("mul_valid", mul_valid, m_mv);
            check("mul_a", mul_a, m_ma);
            check("mul_b", mul_b, m_mb);
            check("res0_valid", res0_valid, rv0);
            check("res1_valid", res1_valid, rv1);
            if (rv0) check("res0_data", {res0_exception, res0_data}, q0[0].dat);
            if (rv1) check("res1_data", {res1_exception, res1_data}, q1[0].dat);
            check("busy", busy, (q0.size() + q1.size()) > 0);
        end
        if (reset) begin
            q0.delete();
            q1.delete();
            m_ptr   = 0;
            m_mv    = 0;
            m_ma    = '0;
            m_mb    = '0;
            started = 1;
        end else begin
            if (rv0 && res0_ready) void'(q0.pop_front());
            if (rv1 && res1_ready) void'(q1.pop_front());
            m_mv = g0 || g1;
            if (g0) begin
                q0.push_back('{dat: fmul_ref(req0_a, req0_b), vis: ne + L + 3});
                m_ma = req0_a; m_mb = req0_b; m_ptr = 1;
            end else if (g1) begin
                q1.push_back('{dat: fmul_ref(req1_a, req1_b), vis: ne + L + 3});
                m_ma = req1_a; m_mb = req1_b; m_ptr = 0;
            end
        end
        ne++;
    end

    int          lat, n0, n1, nres, nbusy, issues, alt_bad, prev_g, g;
    bit          seen0, seen1;
    logic [31:0] got0, got1;

    initial begin
        reset = 1; req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res0_ready = 1; res1_ready = 1;
        repeat (2) @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #3;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_res0_valid", res0_valid, 0);

        // Single transfer: 0.5 * 2.0
        @(negedge clk);
        reset = 0; req1_valid = 0;
        req0_a = 32'h3F000000; req0_b = 32'h40000000;
        #3 check("t1_ready", req0_ready, 1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            req0_valid = 0;
            #3;
            if (k == 1) begin
                check("t1_mul_valid", mul_valid, 1);
                check("t1_mul_a", mul_a, 32'h3F000000);
            end
            if (res0_valid) begin
                lat = k - 1;
                check("t1_res0_data", res0_data, 32'h3F800000);
                check("t1_res0_exc", res0_exception, 0);
            end
        end
        check("t1_latency_edges", lat, 5);

        // Both valid on the first cycle after reset
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1; req1_a = 32'h40800000; req1_b = 32'h3F000000;
        #3;
        check("t2_first_ready0", req0_ready, 1);
        check("t2_first_ready1", req1_ready, 0);
        @(negedge clk); req0_valid = 0;
        #3 check("t2_second_ready1", req1_ready, 1);
        @(negedge clk); req1_valid = 0;
        seen0 = 0; seen1 = 0; got0 = '0; got1 = '0;
        for (int k = 0; k < 20 && !(seen0 && seen1); k++) begin
            #3;
            if (res0_valid && !seen0) begin seen0 = 1; got0 = res0_data; end
            if (res1_valid && !seen1) begin seen1 = 1; got1 = res1_data; end
            @(negedge clk);
        end
        check("t2_res0", got0, 32'h40C00000);
        check("t2_res1", got1, 32'h40000000);

        // Requester 0 blocked by credits while requester 1 keeps going
        res0_ready = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req0_valid = 1; req0_a = 32'h3F800000 + 32'(i) * 32'h00100000; req0_b = 32'h40000000;
            req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000 + 32'(i) * 32'h00080000;
            #3;
            n0 += int'(req0_ready);
            n1 += int'(req1_ready);
        end
        check("t3_req0_transfers", n0, 4);
        check("t3_req1_transfers", n1, 5);
        @(negedge clk);
        req1_valid = 0; res0_ready = 1;
        #3 check("t3_req0_stalled", req0_ready, 0);
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            res0_ready = 0;
            #3 n0 += int'(req0_ready);
        end
        check("t3_after_one_pop", n0, 1);
        @(negedge clk);
        req0_valid = 0; res0_ready = 1;
        repeat (12) @(negedge clk);

        // Both streaming: strict alternation, one issue per cycle
        issues = 0; alt_bad = 0; prev_g = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req0_valid = 1; req0_a = (i == 5) ? 32'h7F800000 : 32'h40000000 + 32'(i) * 32'h00080000;
            req0_b = 32'h3FC00000;
            req1_valid = 1; req1_a = 32'h3F000000 + 32'(i) * 32'h00040000; req1_b = 32'hC0000000;
            #3;
            g = req0_ready ? 0 : (req1_ready ? 1 : -1);
            if (g >= 0) issues++;
            if (g >= 0 && prev_g >= 0 && g == prev_g) alt_bad++;
            prev_g = g;
        end
        check("t4_issues", issues, 16);
        check("t4_alternation", alt_bad, 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (12) @(negedge clk);

        // Reset in the middle of operations discards everything and restores credits
        res0_ready = 0; res1_ready = 0;
        req0_valid = 1; req0_a = 32'h40400000; req0_b = 32'h40400000;
        repeat (3) @(negedge clk);
        req0_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        nres = 0; nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            #3;
            nres += int'(res0_valid | res1_valid);
            nbusy += int'(busy);
            @(negedge clk);
        end
        check("t5_no_results", nres, 0);
        check("t5_not_busy", nbusy, 0);
        n0 = 0; n1 = 0;
        req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1; req1_valid = 1;
            #3;
            n0 += int'(req0_ready);
            n1 += int'(req1_ready);
            @(negedge clk);
        end
        check("t5_req0_credits", n0, 4);
        check("t5_req1_credits", n1, 4);
        req0_valid = 0; req1_valid = 0; res0_ready = 1; res1_ready = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (!busy) break;
        end
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
